// File: rtl/write_buffer_axi_pkg.sv
// Shared state encodings, AXI constants and entry layout for the AXI write buffer.
package write_buffer_axi_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned ENTRY_W = 68;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wb_entry_t;

endpackage

// File: rtl/write_buffer_axi_fifo.sv
// Circular entry store for the write buffer: tail push, head peek/pop, per-slot valid view.
module wbuf_fifo
  import write_buffer_axi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = ENTRY_W,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [CW-1:0]          count_o,
  output logic                   full_o,
  output logic [DEPTH*WIDTH-1:0] slots_o,
  output logic [DEPTH-1:0]       valid_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    offset;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  // A slot is live when its distance from the head is below the entry count.
  always_comb begin
    valid_o = '0;
    slots_o = '0;
    offset  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset                      = PW'(i) - rd_ptr_q;
      valid_o[i]                  = ({1'b0, offset} < count_q);
      slots_o[i*WIDTH +: WIDTH]   = mem_q[i];
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/write_buffer_axi.sv
// Posted-store write buffer draining one single-beat AXI write at a time, in FIFO order,
// with a read-after-write hazard compare against every buffered entry.
module write_buffer_axi
  import write_buffer_axi_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        WREN,
  input  logic [31:0] WADDR,
  input  logic [3:0]  WSTRB,
  input  logic [31:0] WDATA,
  output logic        FULL,
  output logic        EMPTY,
  input  logic [31:0] HAZ_ADDR,
  output logic        HAZ_HIT,
  output logic        OVERFLOW,
  output logic        BERR,
  output logic [31:0] M_AXI_AWADDR,
  output logic [7:0]  M_AXI_AWLEN,
  output logic [2:0]  M_AXI_AWSIZE,
  output logic [1:0]  M_AXI_AWBURST,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WLAST,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic        M_AXI_BID,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  wb_entry_t               push_entry;
  wb_entry_t               head_entry;
  wb_entry_t [DEPTH-1:0]   slots;
  logic [DEPTH-1:0]        slot_valid;
  logic [CW-1:0]           count;
  logic                    fifo_full;
  logic                    push;
  logic                    pop;
  logic                    aw_done;
  logic                    w_done;
  logic                    haz_hit;

  logic [1:0]  state_q,    state_d;
  logic        awvalid_q,  awvalid_d;
  logic        wvalid_q,   wvalid_d;
  logic [31:0] awaddr_q,   awaddr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [3:0]  wstrb_q,    wstrb_d;
  logic        overflow_q, overflow_d;
  logic        berr_q,     berr_d;

  logic unused_bits;

  assign push_entry = '{addr: WADDR, strb: WSTRB, data: WDATA};

  // A push that lands on the pop edge fits even when full, so the count holds at DEPTH.
  assign pop  = (state_q == S_RESP) && M_AXI_BVALID;
  assign push = WREN && (!fifo_full || pop);

  wbuf_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .head_o  (head_entry),
    .count_o (count),
    .full_o  (fifo_full),
    .slots_o (slots),
    .valid_o (slot_valid)
  );

  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q  || M_AXI_WREADY;

  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    overflow_d = overflow_q | (WREN & fifo_full & ~pop);
    berr_d     = berr_q;
    case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          state_d   = S_ADDR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = {head_entry.addr[31:2], 2'b00};
          wdata_d   = head_entry.data;
          wstrb_d   = head_entry.strb;
        end
      end
      S_ADDR: begin
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q  & ~M_AXI_WREADY;
        if (aw_done && w_done) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (M_AXI_BVALID) begin
          state_d = S_IDLE;
          if (M_AXI_BRESP != AXI_RESP_OKAY) begin
            berr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      overflow_q <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      overflow_q <= overflow_d;
      berr_q     <= berr_d;
    end
  end

  // The in-flight entry stays in the store until its B handshake, so it is covered here too.
  always_comb begin
    haz_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (slots[i].addr[31:2] == HAZ_ADDR[31:2])) begin
        haz_hit = 1'b1;
      end
    end
  end

  assign unused_bits = ^{M_AXI_BID, HAZ_ADDR[1:0], head_entry.addr[1:0], slots};

  assign FULL          = fifo_full;
  assign EMPTY         = (count == '0) && (state_q == S_IDLE);
  assign HAZ_HIT       = haz_hit;
  assign OVERFLOW      = overflow_q;
  assign BERR          = berr_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = AXI_SIZE_WORD;
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == S_RESP);

endmodule

// File: tb/tb_write_buffer_axi.sv
// Bench for write_buffer_axi: queue-based reference checked every cycle, plus directed scenarios.
module tb_write_buffer_axi;

  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        WREN;
  logic [31:0] WADDR;
  logic [3:0]  WSTRB;
  logic [31:0] WDATA;
  logic        FULL;
  logic        EMPTY;
  logic [31:0] HAZ_ADDR;
  logic        HAZ_HIT;
  logic        OVERFLOW;
  logic        BERR;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWVALID;
  logic        AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WVALID;
  logic        WREADY;
  logic        BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        M_AXI_BREADY;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  write_buffer_axi #(.DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .WREN          (WREN),
    .WADDR         (WADDR),
    .WSTRB         (WSTRB),
    .WDATA         (WDATA),
    .FULL          (FULL),
    .EMPTY         (EMPTY),
    .HAZ_ADDR      (HAZ_ADDR),
    .HAZ_HIT       (HAZ_HIT),
    .OVERFLOW      (OVERFLOW),
    .BERR          (BERR),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWLEN   (M_AXI_AWLEN),
    .M_AXI_AWSIZE  (M_AXI_AWSIZE),
    .M_AXI_AWBURST (M_AXI_AWBURST),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WLAST   (M_AXI_WLAST),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (WREADY),
    .M_AXI_BID     (BID),
    .M_AXI_BRESP   (BRESP),
    .M_AXI_BVALID  (BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY)
  );

  always #5 CLK = ~CLK;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: stores live in a queue {addr,strb,data}; one transaction at a time.
  logic [67:0] mq[$];
  bit          m_busy, m_awp, m_wp, m_resp, m_ovf, m_berr;
  logic [31:0] m_awaddr, m_wdata;
  logic [3:0]  m_wstrb;

  initial begin : model_and_compare
    bit pop_now, accept, hz;
    forever begin
      @(posedge CLK);
      if (RST) begin
        mq.delete();
        m_busy = 0; m_awp = 0; m_wp = 0; m_resp = 0; m_ovf = 0; m_berr = 0;
        m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
      end else begin
        pop_now = m_resp && BVALID;
        accept  = WREN && ((mq.size() < DEPTH) || pop_now);
        if (WREN && !accept) m_ovf = 1;
        if (pop_now) begin
          if (BRESP != 2'b00) m_berr = 1;
          void'(mq.pop_front());
          m_resp = 0;
          m_busy = 0;
        end else if (m_busy && !m_resp) begin
          if (AWREADY) m_awp = 0;
          if (WREADY)  m_wp  = 0;
          if (!m_awp && !m_wp) m_resp = 1;
        end else if (!m_busy && mq.size() != 0) begin
          m_busy   = 1;
          m_awp    = 1;
          m_wp     = 1;
          m_awaddr = {mq[0][67:38], 2'b00};
          m_wstrb  = mq[0][35:32];
          m_wdata  = mq[0][31:0];
        end
        if (accept) mq.push_back({WADDR, WSTRB, WDATA});
      end
      #1;
      hz = 0;
      foreach (mq[j]) if (mq[j][67:38] == HAZ_ADDR[31:2]) hz = 1;
      check1 ("cyc_full",     FULL,          mq.size() == DEPTH);
      check1 ("cyc_empty",    EMPTY,         (mq.size() == 0) && !m_busy);
      check1 ("cyc_haz",      HAZ_HIT,       hz);
      check1 ("cyc_overflow", OVERFLOW,      m_ovf);
      check1 ("cyc_berr",     BERR,          m_berr);
      check1 ("cyc_awvalid",  M_AXI_AWVALID, m_awp);
      check1 ("cyc_wvalid",   M_AXI_WVALID,  m_wp);
      check1 ("cyc_bready",   M_AXI_BREADY,  m_resp);
      check32("cyc_awaddr",   M_AXI_AWADDR,  m_awaddr);
      check32("cyc_wdata",    M_AXI_WDATA,   m_wdata);
      check32("cyc_wstrb",    32'(M_AXI_WSTRB), 32'(m_wstrb));
      check32("cyc_awlen",    32'(M_AXI_AWLEN),   32'd0);
      check32("cyc_awsize",   32'(M_AXI_AWSIZE),  32'd2);
      check32("cyc_awburst",  32'(M_AXI_AWBURST), 32'd1);
      check1 ("cyc_wlast",    M_AXI_WLAST,   1'b1);
    end
  end

  task automatic expect_aw(input logic [31:0] addr, input logic [31:0] data);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (M_AXI_AWVALID) begin
        seen = 1;
        check32("drain_awaddr", M_AXI_AWADDR, addr);
        check32("drain_wdata",  M_AXI_WDATA,  data);
      end
      @(negedge CLK);
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got no AWVALID, expected AWADDR 0x%08h", addr);
    end
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 20 && !EMPTY; i++) @(negedge CLK);
    check1(name, EMPTY, 1'b1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    RST = 1; WREN = 0; WADDR = '0; WSTRB = '0; WDATA = '0; HAZ_ADDR = '0;
    AWREADY = 0; WREADY = 0; BID = 0; BRESP = 2'b00; BVALID = 0;
    repeat (3) @(negedge CLK);

    check1 ("rst_awvalid",  M_AXI_AWVALID, 1'b0);
    check1 ("rst_wvalid",   M_AXI_WVALID,  1'b0);
    check1 ("rst_bready",   M_AXI_BREADY,  1'b0);
    check1 ("rst_empty",    EMPTY,         1'b1);
    check1 ("rst_full",     FULL,          1'b0);
    check1 ("rst_overflow", OVERFLOW,      1'b0);
    check1 ("rst_berr",     BERR,          1'b0);
    check32("rst_awaddr",   M_AXI_AWADDR,  32'h0);
    check32("rst_wdata",    M_AXI_WDATA,   32'h0);
    RST = 0;

    // Single store with immediate handshakes
    AWREADY = 1; WREADY = 1;
    WREN = 1; WADDR = 32'h8000_0104; WSTRB = 4'b0011; WDATA = 32'hDEAD_BEEF;
    @(negedge CLK);
    WREN = 0;
    check1 ("single_awvalid_t",  M_AXI_AWVALID, 1'b0);
    check1 ("single_notempty",   EMPTY,         1'b0);
    @(negedge CLK);
    check1 ("single_awvalid_t1", M_AXI_AWVALID, 1'b1);
    check1 ("single_wvalid_t1",  M_AXI_WVALID,  1'b1);
    check32("single_awaddr",     M_AXI_AWADDR,  32'h8000_0104);
    check32("single_wstrb",      32'(M_AXI_WSTRB), 32'h3);
    check32("single_wdata",      M_AXI_WDATA,   32'hDEAD_BEEF);
    @(negedge CLK);
    check1 ("single_awvalid_low", M_AXI_AWVALID, 1'b0);
    check1 ("single_bready",      M_AXI_BREADY,  1'b1);
    BVALID = 1; BRESP = 2'b00;
    @(negedge CLK);
    BVALID = 0;
    check1 ("single_empty",      EMPTY,        1'b1);
    check1 ("single_bready_low", M_AXI_BREADY, 1'b0);
    check1 ("single_berr",       BERR,         1'b0);

    // Split handshake: W accepted three cycles after AW
    AWREADY = 1; WREADY = 0;
    WREN = 1; WADDR = 32'h0000_0200; WSTRB = 4'hF; WDATA = 32'h1234_5678;
    @(negedge CLK);
    WREN = 0;
    @(negedge CLK);
    check1("split_awvalid", M_AXI_AWVALID, 1'b1);
    check1("split_wvalid",  M_AXI_WVALID,  1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check1("split_aw_dropped", M_AXI_AWVALID, 1'b0);
      check1("split_w_held",     M_AXI_WVALID,  1'b1);
      check1("split_no_resp",    M_AXI_BREADY,  1'b0);
    end
    WREADY = 1;
    @(negedge CLK);
    check1("split_w_dropped", M_AXI_WVALID, 1'b0);
    check1("split_resp",      M_AXI_BREADY, 1'b1);
    BVALID = 1;
    @(negedge CLK);
    BVALID = 0;
    check1("split_empty", EMPTY, 1'b1);

    // Fill, overflow, push on the pop edge, ordered drain
    AWREADY = 0; WREADY = 0;
    for (int k = 0; k < 5; k++) begin
      WREN = 1; WADDR = 32'h1000 + 32'(k * 16); WSTRB = 4'hF; WDATA = 32'hA000_0000 + 32'(k);
      @(negedge CLK);
      check1("fill_full", FULL,     k >= 3);
      check1("fill_ovf",  OVERFLOW, k == 4);
    end
    WREN = 0;
    check1 ("fill_head_valid", M_AXI_AWVALID, 1'b1);
    check32("fill_head_addr",  M_AXI_AWADDR,  32'h1000);
    AWREADY = 1; WREADY = 1;
    @(negedge CLK);
    check1("fill_bready",   M_AXI_BREADY, 1'b1);
    check1("pre_pop_full",  FULL,         1'b1);
    BVALID = 1; BRESP = 2'b00;
    WREN = 1; WADDR = 32'h1050; WSTRB = 4'hF; WDATA = 32'hA000_0005;
    @(negedge CLK);
    WREN = 0;
    check1("pop_push_full", FULL,     1'b1);
    check1("pop_push_ovf",  OVERFLOW, 1'b1);
    HAZ_ADDR = 32'h1052; #1;
    check1("pop_push_haz_new", HAZ_HIT, 1'b1);
    HAZ_ADDR = 32'h1000; #1;
    check1("pop_push_haz_old", HAZ_HIT, 1'b0);
    expect_aw(32'h1010, 32'hA000_0001);
    expect_aw(32'h1020, 32'hA000_0002);
    expect_aw(32'h1030, 32'hA000_0003);
    expect_aw(32'h1050, 32'hA000_0005);
    wait_empty("drain_empty");
    BVALID = 0;

    // Hazard window and error response
    AWREADY = 1; WREADY = 1; BRESP = 2'b00;
    WREN = 1; WADDR = 32'h100; WSTRB = 4'h1; WDATA = 32'h55;
    @(negedge CLK);
    WREN = 0;
    HAZ_ADDR = 32'h103; #1;
    check1("haz_same_word", HAZ_HIT, 1'b1);
    HAZ_ADDR = 32'h104; #1;
    check1("haz_next_word", HAZ_HIT, 1'b0);
    HAZ_ADDR = 32'h103;
    @(negedge CLK);
    check1("haz_in_flight", HAZ_HIT, 1'b1);
    @(negedge CLK);
    check1("err_bready", M_AXI_BREADY, 1'b1);
    BVALID = 1; BRESP = 2'b10;
    @(negedge CLK);
    BVALID = 0; BRESP = 2'b00;
    check1("err_berr",   BERR,    1'b1);
    check1("err_popped", EMPTY,   1'b1);
    check1("err_no_haz", HAZ_HIT, 1'b0);

    // Reset while a write is outstanding
    AWREADY = 0; WREADY = 0;
    WREN = 1; WADDR = 32'h300; WSTRB = 4'hF; WDATA = 32'h77;
    @(negedge CLK);
    WREN = 0;
    @(negedge CLK);
    check1("midrst_busy", M_AXI_AWVALID, 1'b1);
    RST = 1;
    @(negedge CLK);
    RST = 0;
    check1 ("midrst_awvalid", M_AXI_AWVALID, 1'b0);
    check1 ("midrst_wvalid",  M_AXI_WVALID,  1'b0);
    check1 ("midrst_empty",   EMPTY,         1'b1);
    check1 ("midrst_berr",    BERR,          1'b0);
    check32("midrst_awaddr",  M_AXI_AWADDR,  32'h0);
    AWREADY = 1; WREADY = 1;
    repeat (3) @(negedge CLK);
    check1("midrst_stays_idle", EMPTY, 1'b1);

    // Randomized traffic against the reference
    for (int n = 0; n < 4000; n++) begin
      RST      = ($urandom_range(0, 299) == 0);
      WREN     = ($urandom_range(0, 9) < 4);
      WADDR    = 32'h4000 | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      WSTRB    = 4'($urandom);
      WDATA    = $urandom;
      HAZ_ADDR = 32'h4000 | ($urandom_range(0, 9) << 2) | $urandom_range(0, 3);
      AWREADY  = ($urandom_range(0, 9) < 6);
      WREADY   = ($urandom_range(0, 9) < 6);
      BVALID   = ($urandom_range(0, 1) == 1);
      BRESP    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      BID      = 1'($urandom);
      @(negedge CLK);
    end
    RST = 0; WREN = 0; BVALID = 0;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/write_buffer_axi.md
WRITE_BUFFER_AXI -- requirements
Module: write_buffer_axi

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered write entries; SHALL be a power of two, at least 2.
REQ-002 One clock and one reset: CLK drives all logic, including the AXI master side; RST is synchronous and active-high.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 RST  in  1  synchronous active-high reset.
REQ-005 WREN  in  1  push a store request.
REQ-006 WADDR  in  32  store byte address; bits [1:0] are ignored.
REQ-007 WSTRB  in  4  store byte strobes.
REQ-008 WDATA  in  32  store data.
REQ-009 FULL  out  1  combinational; high when the entry count equals DEPTH.
REQ-010 EMPTY  out  1  combinational; high when the count is 0 and the FSM is in S_IDLE.
REQ-011 HAZ_ADDR  in  32  load address for the read-after-write check.
REQ-012 HAZ_HIT  out  1  combinational; high when any valid entry, including the in-flight one, has WADDR[31:2] equal to HAZ_ADDR[31:2].
REQ-013 OVERFLOW  out  1  sticky; set when a push is attempted while FULL.
REQ-014 BERR  out  1  sticky; set when a write response is not OKAY.
REQ-015 M_AXI_AWADDR  out  32  head entry address, forced to {WADDR[31:2],2'b00}.
REQ-016 M_AXI_AWLEN/AWSIZE/AWBURST  out  8/3/2  constants 0, 3'b010, 2'b01.
REQ-017 M_AXI_AWVALID  out  1  registered.
REQ-018 M_AXI_AWREADY  in  1.
REQ-019 M_AXI_WDATA / M_AXI_WSTRB  out  32/4  head entry data and strobes.
REQ-020 M_AXI_WLAST  out  1  constant 1.
REQ-021 M_AXI_WVALID  out  1  registered.
REQ-022 M_AXI_WREADY  in  1.
REQ-023 M_AXI_BID  in  1  ignored.
REQ-024 M_AXI_BRESP  in  2.
REQ-025 M_AXI_BVALID  in  1.
REQ-026 M_AXI_BREADY  out  1  high only in S_RESP.

Function
REQ-027 Push: WREN high at an edge with FULL low SHALL store {WADDR,WSTRB,WDATA} at the tail and increment the count.
REQ-028 Push while FULL: the request SHALL be dropped, the count left unchanged, and OVERFLOW set.
REQ-029 Pop: an entry SHALL be popped only on the B handshake (BVALID and BREADY at the same edge); this is the only way an entry leaves the buffer.
REQ-030 Push and pop at the same edge SHALL leave the count unchanged; the pointers wrap modulo DEPTH.
REQ-031 FSM states SHALL be S_IDLE, S_ADDR and S_RESP, with these transitions:
- S_IDLE to S_ADDR when the count is non-zero.
- S_ADDR to S_RESP once both the AW and W handshakes have completed, in the same cycle or in different cycles.
- S_RESP to S_IDLE on BVALID.
REQ-032 On entry to S_ADDR, AWVALID and WVALID SHALL both rise; each SHALL fall at the edge after its own handshake and SHALL stay high until that handshake.
REQ-033 The AXI address, data and strobe outputs SHALL stay stable from S_ADDR entry until S_RESP exits.
REQ-034 Latency: a WREN accepted at edge t into an empty buffer SHALL produce AWVALID=WVALID=1 after edge t+1.
REQ-035 The block SHALL keep at most one outstanding transaction, issued in FIFO order.
REQ-036 A BRESP other than 2'b00 SHALL still pop the entry and SHALL set BERR.

Reset
REQ-037 When RST is high, after that edge:
- count, pointers, OVERFLOW and BERR SHALL be 0.
- AWVALID, WVALID and BREADY SHALL be 0.
- the state SHALL be S_IDLE.
- the AXI address and data outputs SHALL be 0.
REQ-038 A reset in mid-transaction SHALL abandon the in-flight write, with no completion required.

Structure
REQ-039 A shared package SHALL hold the state encodings, AXI_SIZE_WORD=3'b010, AXI_BURST_INCR=2'b01 and AXI_RESP_OKAY=2'b00.
REQ-040 Entry storage and pointers SHALL be one sub-module, wbuf_fifo (parameter DEPTH, width 68, with head peek); the FSM and hazard compare stay in write_buffer_axi.

Verification
REQ-041 Single store: WREN with 0x8000_0104, strb 4'b0011, data 0xDEAD_BEEF; AWREADY=WREADY=1 and BVALID one cycle later. Required: AWADDR=0x8000_0104, WSTRB=4'b0011, valids after edge t+1, and EMPTY=1 after the B handshake.
REQ-042 Split handshake: WREADY is 3 cycles later than AWREADY. Required: AWVALID drops first, WVALID is held, and S_RESP is entered only after WREADY.
REQ-043 Fill and overflow: 5 pushes with DEPTH=4 and AWREADY=0. Required: FULL after the 4th push, the 5th dropped, OVERFLOW=1, and the 4 entries drained in order.
REQ-044 Push at the pop edge while count=4. Required: the count stays 4 and FULL stays 1.
REQ-045 Hazard and error: buffered 0x100, HAZ_ADDR 0x103 gives HAZ_HIT=1 and 0x104 gives 0; BRESP=2'b10 gives BERR=1 and the entry popped.
